// File: rtl/load_store_unit.sv
// load_store_unit: load/store initiator onto a word-wide byte-enabled bus; LSU_MISALIGN_EN enables two-beat split accesses.
// Latency: done at accept+2 (one beat), +3 (split), +1 (no-op or misalign error); each bus wait cycle adds 1.
// Backpressure: one access in flight, ready low from acceptance until the cycle after done; bus beat held until bus_ack.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic [31:0] dout,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t state;

  logic [29:0] r_word;
  logic [1:0]  r_off, r_size;
  logic        r_sign, r_rd, r_split;
  logic [3:0]  r_mask;
  logic [31:0] r_din, r_raw0;

  function automatic logic [3:0] size_mask(input logic [1:0] s);
    case (s)
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0011;
      2'b11:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [3:0]  in_mask, in_be;
  logic [2:0]  in_n;
  logic        in_noop, in_split;
  logic [31:0] in_din;

  always_comb begin
    in_mask  = size_mask(memSize);
    in_n     = (memSize == 2'b11) ? 3'd4 : {1'b0, memSize};
    in_split = ({1'b0, addr[1:0]} + in_n) > 3'd4;
    in_noop  = !(memWrite || memRead) || (memSize == 2'b00);
    in_be    = in_mask << addr[1:0];
    in_din   = din & lane_mask(in_mask);
  end

  // Second-beat lane math: the bytes that spilled past lane 3 move down to lane 0.
  logic [2:0]  sh1;
  logic [3:0]  b1_be;
  logic [31:0] b1_wdata, rd0, raw, ext;
  logic        beat_ack, last_ack;

  always_comb begin
    sh1      = 3'd4 - {1'b0, r_off};
    b1_be    = r_mask >> sh1;
    b1_wdata = r_din >> {sh1, 3'b000};
    rd0      = bus_rdata >> {r_off, 3'b000};
    raw      = (r_split ? (r_raw0 | (bus_rdata << {sh1, 3'b000})) : rd0) & lane_mask(r_mask);
    case (r_size)
      2'b01:   ext = {{24{r_sign & raw[7]}}, raw[7:0]};
      2'b10:   ext = {{16{r_sign & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
    beat_ack = bus_req && bus_ack;
    last_ack = beat_ack && ((state == BEAT1) || (state == BEAT0 && !r_split));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      dout      <= '0;
      r_word    <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_sign    <= 1'b0;
      r_rd      <= 1'b0;
      r_split   <= 1'b0;
      r_mask    <= '0;
      r_din     <= '0;
      r_raw0    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && ready) begin
            r_word  <= addr[31:2];
            r_off   <= addr[1:0];
            r_size  <= memSize;
            r_sign  <= memSign;
            r_rd    <= !memWrite && memRead;
            r_split <= in_split;
            r_mask  <= in_mask;
            r_din   <= in_din;
            ready   <= 1'b0;
            if (in_noop) begin
              state <= DONE;
              done  <= 1'b1;
            end
`ifndef LSU_MISALIGN_EN
            else if (in_split) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
`endif
            else begin
              state     <= BEAT0;
              bus_req   <= 1'b1;
              bus_we    <= memWrite;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= in_be;
              bus_wdata <= in_din << {addr[1:0], 3'b000};
            end
          end
        end
        BEAT0, BEAT1: begin
          if (last_ack) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (r_rd) dout <= ext;
          end else if (beat_ack) begin
            state     <= BEAT1;
            bus_addr  <= {r_word + 30'd1, 2'b00};
            bus_be    <= b1_be;
            bus_wdata <= b1_wdata;
            r_raw0    <= rd0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: zero/multi-wait bus model over a little-endian RAM, queued expected beats and responses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        ready;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [1:0]  memSize = 2'b00;
  logic        memSign = 1'b0;
  logic [31:0] dout;
  logic        done, err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .addr(addr), .din(din),
    .memWrite(memWrite), .memRead(memRead), .memSize(memSize), .memSign(memSign),
    .dout(dout), .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic err; logic [31:0] dout; int due; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;
  rsp_t  rsp_q[$];
  beat_t beat_q[$];

  // Bus model: acks after wait_n wait cycles, checks each beat against the expected queue.
  logic [31:0] ram [0:15] = '{default: 32'h0};
  int wait_n = 0;
  int wcnt = 0;
  int reqcyc = 0;
  logic [68:0] snap;

  always @(negedge clk) begin
    beat_t b;
    bus_ack = 1'b0;
    if (bus_req !== 1'b1) wcnt = 0;
    else begin
      reqcyc++;
      if (wcnt == 0) snap = {bus_we, bus_addr, bus_be, bus_wdata};
      else chk("bus_stable", {bus_we, bus_addr, bus_be, bus_wdata}, snap);
      if (wcnt == wait_n) begin
        wcnt = 0;
        bus_ack = 1'b1;
        bus_rdata = ram[bus_addr[5:2]];
        if (bus_we)
          for (int i = 0; i < 4; i++)
            if (bus_be[i]) ram[bus_addr[5:2]][8*i +: 8] = bus_wdata[8*i +: 8];
        if (beat_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=addr %0h be %0h expected=no beat", bus_addr, bus_be);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", bus_addr, b.addr);
          chk("beat_we_be", {bus_we, bus_be}, {b.we, b.be});
          if (b.we) chk("beat_wdata", bus_wdata, b.wdata);
        end
      end else wcnt++;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    rsp_t r;
    if (rst && done === 1'b1) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=idle");
      end else begin
        r = rsp_q.pop_front();
        chk("done_cycle", cyc, r.due);
        chk("err", err, r.err);
        chk("dout", dout, r.dout);
      end
    end else if (rst && err === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL err_without_done actual=1 expected=0");
    end
  end

  logic [31:0] model_dout = '0;

  task automatic beat(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic start(input logic wr, input logic rd, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic e, input logic [31:0] rdval);
    rsp_t r;
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_req", ready, 1);
    if (rd && !wr && sz != 2'b00 && !e) model_dout = rdval;
    r.err = e; r.dout = model_dout; r.due = cyc + lat;
    rsp_q.push_back(r);
    memWrite = wr; memRead = rd; memSize = sz; memSign = sg; addr = a; din = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0; memWrite = 1'b0; memRead = 1'b0;
  endtask

  task automatic finish_op();
    int n = 0;
    while (rsp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (rsp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending %0d expected=0", rsp_q.size());
      rsp_q.delete();
    end
  endtask

  task automatic op(input logic wr, input logic rd, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] d, input int lat,
                    input logic e, input logic [31:0] rdval);
    start(wr, rd, sz, sg, a, d, lat, e, rdval);
    finish_op();
  endtask

  initial begin
    int n;
    int rc;
    logic [31:0] tgt;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b1;
    @(negedge clk);

    // stores
    beat(1, 32'h0, 4'b1111, 32'h12345678); op(1, 0, 2'b11, 0, 32'h0, 32'h12345678, 2, 0, 0);
    beat(1, 32'h4, 4'b0011, 32'h00005678); op(1, 0, 2'b10, 0, 32'h4, 32'h12345678, 2, 0, 0);
    beat(1, 32'h4, 4'b0100, 32'h00FF0000); op(1, 0, 2'b01, 0, 32'h6, 32'hFFFFFFFF, 2, 0, 0);
    chk("ram_word0", ram[0], 32'h12345678);
    chk("ram_word1", ram[1], 32'h00FF5678);

    // loads and extension
    beat(0, 32'h4, 4'b0110, 0); op(0, 1, 2'b10, 1, 32'h5, 0, 2, 0, 32'hFFFFFF56);
    beat(0, 32'h4, 4'b0110, 0); op(0, 1, 2'b10, 0, 32'h5, 0, 2, 0, 32'h0000FF56);
    beat(0, 32'h0, 4'b0001, 0); op(0, 1, 2'b01, 1, 32'h0, 0, 2, 0, 32'h00000078);
    beat(0, 32'h0, 4'b0001, 0); op(0, 1, 2'b01, 0, 32'h0, 0, 2, 0, 32'h00000078);
    beat(0, 32'h0, 4'b1100, 0); op(0, 1, 2'b10, 0, 32'h2, 0, 2, 0, 32'h00001234);

    // no-ops: no bus traffic, done next cycle, dout held
    rc = reqcyc;
    op(0, 0, 2'b11, 0, 32'h8, 32'hDEADBEEF, 1, 0, 0);
    op(0, 1, 2'b00, 0, 32'h8, 0, 1, 0, 0);
    chk("noop_no_bus", reqcyc, rc);

    // word-boundary crossing
`ifdef LSU_MISALIGN_EN
    beat(0, 32'h0, 4'b1000, 0); beat(0, 32'h4, 4'b0111, 0);
    op(0, 1, 2'b11, 0, 32'h3, 0, 3, 0, 32'hFF567812);
`else
    rc = reqcyc;
    op(0, 1, 2'b11, 0, 32'h3, 0, 1, 1, 0);
    op(1, 0, 2'b10, 0, 32'h3, 32'hFFFF, 1, 1, 0);
    chk("misalign_no_bus", reqcyc, rc);
    chk("misalign_ram0", ram[0], 32'h12345678);
`endif

    // reset mid-access
    wait_n = 3;
`ifdef LSU_MISALIGN_EN
    beat(0, 32'h0, 4'b1000, 0); beat(0, 32'h4, 4'b0111, 0);
    start(0, 1, 2'b11, 0, 32'h3, 0, 3, 0, 32'hFF567812);
    tgt = 32'h4;
`else
    beat(0, 32'h0, 4'b1111, 0);
    start(0, 1, 2'b11, 0, 32'h0, 0, 5, 0, 32'h12345678);
    tgt = 32'h0;
`endif
    n = 0;
    while (!(bus_req === 1'b1 && bus_addr === tgt) && n < 40) begin @(negedge clk); n++; end
    chk("rst_target_beat", {bus_req, bus_addr}, {1'b1, tgt});
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_dout", dout, 0);
    rsp_q.delete();
    beat_q.delete();
    model_dout = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_n = 0;
    @(negedge clk);
    chk("postrst_ready", ready, 1);
    chk("postrst_dout", dout, 0);
    beat(0, 32'h0, 4'b1111, 0); op(0, 1, 2'b11, 0, 32'h0, 0, 2, 0, 32'h12345678);

    // wait states
    wait_n = 3;
`ifdef LSU_MISALIGN_EN
    beat(1, 32'h0, 4'b1100, 32'hCCDD0000); beat(1, 32'h4, 4'b0011, 32'h0000AABB);
    op(1, 0, 2'b11, 0, 32'h2, 32'hAABBCCDD, 9, 0, 0);
    chk("wait_ram0_hi", ram[0][31:16], 16'hCCDD);
    chk("wait_ram1_lo", ram[1][15:0], 16'hAABB);
`else
    beat(1, 32'h8, 4'b1111, 32'hAABBCCDD);
    op(1, 0, 2'b11, 0, 32'h8, 32'hAABBCCDD, 5, 0, 0);
    chk("wait_ram2", ram[2], 32'hAABBCCDD);
`endif
    wait_n = 0;
    chk("beats_left", beat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
